// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the 4-way round-robin mux arbiter.
// State encodings, requester count and select width live here for all arbiter files.
package mux4_rr_arbiter_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic logic [NREQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between the arbiter (master) and the requesters (slave).
interface mux4_rr_arbiter_if #(
  parameter int CNT_W = 4
);
  import mux4_rr_arbiter_pkg::*;

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  gnt;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic [CNT_W-1:0] tenure;

  modport master (
    input  req,
    output gnt,
    output sel,
    output busy,
    output tenure
  );

  modport slave (
    output req,
    input  gnt,
    input  sel,
    input  busy,
    input  tenure
  );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin pick: first asserted req after 'last', wrapping, with 'last' itself lowest.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  logic [SEL_W-1:0] idx;

  // Scan from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    winner = last;
    any    = 1'b0;
    idx    = last;
    for (int k = NREQ; k >= 1; k--) begin
      idx = last + SEL_W'(k);
      if (req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux with bounded tenure and a one-cycle gap between owners.
// Optional MUX_ARB_LOCK_EN adds a lock input that suppresses pre-emption while an owner holds the grant.
//
// state   | meaning
// ST_IDLE | no owner, arbitrating every cycle
// ST_BUSY | grant active, tenure counting
// ST_GAP  | one dead cycle after an owner leaves; sel/tenure held, arbitrating
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mux4_rr_arbiter_if.master  bus
`ifdef MUX_ARB_LOCK_EN
  ,
  input  logic               lock
`endif
);

  localparam logic [CNT_W-1:0] TEN_MAX = CNT_W'(HOLD_MAX - 1);

  state_t           state_q, state_nx;
  logic [NREQ-1:0]  gnt_q, gnt_nx;
  logic [SEL_W-1:0] sel_q, sel_nx;
  logic [SEL_W-1:0] last_q, last_nx;
  logic [CNT_W-1:0] tenure_q, tenure_nx;

  logic [SEL_W-1:0] winner;
  logic             any_req;
  logic             at_limit;
  logic             others_wait;
  logic             owner_gone;
  logic             lock_hold;

`ifdef MUX_ARB_LOCK_EN
  assign lock_hold = lock;
`else
  assign lock_hold = 1'b0;
`endif

  rr_pick4 u_pick (
    .req    (bus.req),
    .last   (last_q),
    .winner (winner),
    .any    (any_req)
  );

  assign at_limit    = (tenure_q == TEN_MAX);
  assign others_wait = |(bus.req & ~gnt_q);
  assign owner_gone  = ~bus.req[sel_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      sel_q    <= '0;
      last_q   <= SEL_W'(NREQ - 1);
      tenure_q <= '0;
    end else begin
      state_q  <= state_nx;
      gnt_q    <= gnt_nx;
      sel_q    <= sel_nx;
      last_q   <= last_nx;
      tenure_q <= tenure_nx;
    end
  end

  always_comb begin
    state_nx  = state_q;
    gnt_nx    = gnt_q;
    sel_nx    = sel_q;
    last_nx   = last_q;
    tenure_nx = tenure_q;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (any_req) begin
          state_nx  = ST_BUSY;
          gnt_nx    = onehot4(winner);
          sel_nx    = winner;
          last_nx   = winner;
          tenure_nx = '0;
        end else begin
          state_nx = ST_IDLE;
          gnt_nx   = '0;
        end
      end
      ST_BUSY: begin
        // Tenure freezes on the exit edge so the gap cycle shows the final count.
        if (owner_gone || (at_limit && others_wait && !lock_hold)) begin
          state_nx = ST_GAP;
          gnt_nx   = '0;
        end else if (!at_limit) begin
          tenure_nx = tenure_q + CNT_W'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
        gnt_nx   = '0;
      end
    endcase
  end

  assign bus.gnt    = gnt_q;
  assign bus.sel    = sel_q;
  assign bus.busy   = |gnt_q;
  assign bus.tenure = tenure_q;

endmodule
